// File: rtl/inst_fetch.sv
// Instruction fetch stage: a two-state (IDLE/RUN) sequencer that walks a
// byte-addressed instruction memory four bytes at a time and registers the
// returned word together with its address for the decode stage.
//
// Ports
//   clk          rising-edge system clock
//   rst          synchronous, active-low reset
//   stall        downstream hold request (freezes pc and the fetch outputs)
//   branch_en    redirect request; takes priority over stall
//   branch_addr  redirect target byte address (low two bits are ignored)
//   rom_ce       instruction-memory chip enable (registered)
//   rom_addr     instruction-memory byte address (the internal pc)
//   rom_data     instruction word, returned combinationally by the memory
//   if_pc        address of the instruction on if_inst
//   if_inst      fetched instruction
//   if_valid     if_inst/if_pc carry a real instruction
module inst_fetch #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned INST_W   = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] WORD_MSK = ~ADDR_W'(3);

    state_t            state;
    logic [ADDR_W-1:0] pc;

    // The memory always sees the live pc.
    assign rom_addr = pc;

    // Sequencer, pc and fetch output registers. Capture happens only in RUN,
    // where rom_ce is already 1, so an undriven memory bus is never sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= PC_INIT;
            rom_ce   <= 1'b0;
            if_pc    <= '0;
            if_inst  <= '0;
            if_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= RUN;
                    rom_ce <= 1'b1;
                end
                RUN: begin
                    rom_ce <= 1'b1;
                    if (branch_en) begin
                        // Redirect inserts one bubble; target is word-aligned.
                        pc       <= branch_addr & WORD_MSK;
                        if_pc    <= '0;
                        if_inst  <= '0;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        // pc + 4 wraps naturally at 2^ADDR_W.
                        pc       <= pc + PC_STEP;
                        if_pc    <= pc;
                        if_inst  <= rom_data;
                        if_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
